// File: rtl/gray12_pkg.sv
// Shared mod-12 Gray code constants and bin->gray mapping.
// Also used by graydecoder_12 on the read side.
package gray12_pkg;

  localparam int MOD12 = 12;
  localparam logic [3:0] MAXCNT = 4'd11;

  localparam logic [3:0] G0  = 4'b0000;
  localparam logic [3:0] G1  = 4'b0001;
  localparam logic [3:0] G2  = 4'b0011;
  localparam logic [3:0] G3  = 4'b0010;
  localparam logic [3:0] G4  = 4'b0110;
  localparam logic [3:0] G5  = 4'b0111;
  localparam logic [3:0] G6  = 4'b0101;
  localparam logic [3:0] G7  = 4'b0100;
  localparam logic [3:0] G8  = 4'b1100;
  localparam logic [3:0] G9  = 4'b1101;
  localparam logic [3:0] G10 = 4'b1001;
  localparam logic [3:0] G11 = 4'b1000;

  function automatic logic [3:0] bin2gray12(
    input logic [3:0] b
  );
    logic [3:0] g;
    case (b)
      4'd0:    g = G0;
      4'd1:    g = G1;
      4'd2:    g = G2;
      4'd3:    g = G3;
      4'd4:    g = G4;
      4'd5:    g = G5;
      4'd6:    g = G6;
      4'd7:    g = G7;
      4'd8:    g = G8;
      4'd9:    g = G9;
      4'd10:   g = G10;
      default: g = G11;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/gray12_enc.sv
// Combinational bin->gray lookup for the 12-state sequence.
// Feeds the gray register in graycounter_12.
module gray12_enc
  import gray12_pkg::*;
(
  input  logic [3:0] bin_i,
  output logic [3:0] gray_o
);

  always_comb begin
    gray_o = bin2gray12(bin_i);
  end

endmodule

// File: rtl/graycounter_12.sv
// Mod-12 Gray pointer generator with registered bin/gray/pulses.
// Optional lap bit enabled by GRAYCOUNTER_12_LAP_EN.
module graycounter_12
  import gray12_pkg::*;
#(
  parameter logic [3:0] RESET_VAL = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] load_bin,
  output logic [3:0] bin,
  output logic [3:0] gray,
  output logic       wrap,
`ifdef GRAYCOUNTER_12_LAP_EN
  output logic       lap,
`endif
  output logic       load_err
);

  logic [3:0] bin_q, bin_d;
  logic [3:0] gray_q, gray_d;
  logic       wrap_q, wrap_d;
  logic       lerr_q, lerr_d;
  logic       lap_tgl;

  // Priority: clr > load > inc; corrupt bin recovers to 0.
  always_comb begin
    bin_d   = bin_q;
    wrap_d  = 1'b0;
    lerr_d  = 1'b0;
    lap_tgl = 1'b0;
    if (clr) begin
      bin_d = 4'd0;
    end else if (load) begin
      if (load_bin > MAXCNT) begin
        bin_d  = MAXCNT;
        lerr_d = 1'b1;
      end else begin
        bin_d = load_bin;
      end
    end else if (inc) begin
      if (bin_q == MAXCNT) begin
        bin_d   = 4'd0;
        wrap_d  = 1'b1;
        lap_tgl = 1'b1;
      end else if (bin_q > MAXCNT) begin
        bin_d = 4'd0;
      end else begin
        bin_d = bin_q + 4'd1;
      end
    end
  end

  gray12_enc u_enc (
    .bin_i  (bin_d),
    .gray_o (gray_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      bin_q  <= RESET_VAL;
      gray_q <= bin2gray12(RESET_VAL);
      wrap_q <= 1'b0;
      lerr_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
      lerr_q <= lerr_d;
    end
  end

`ifdef GRAYCOUNTER_12_LAP_EN
  logic lap_q, lap_d;

  always_comb begin
    lap_d = lap_q;
    if (clr) begin
      lap_d = 1'b0;
    end else if (lap_tgl) begin
      lap_d = ~lap_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lap_q <= 1'b0;
    end else begin
      lap_q <= lap_d;
    end
  end

  assign lap = lap_q;
`else
  logic unused_lap;
  assign unused_lap = lap_tgl;
`endif

  assign bin      = bin_q;
  assign gray     = gray_q;
  assign wrap     = wrap_q;
  assign load_err = lerr_q;

endmodule

// File: tb/tb_graycounter_12.sv
// Bench for graycounter_12: directed steps plus random traffic
// against a count-level reference model, two RESET_VAL builds.
module tb_graycounter_12;

  logic       clk = 1'b0;
  logic       reset, inc, clr, load;
  logic [3:0] load_bin;

  logic [3:0] bin0, gray0, bin5, gray5;
  logic       wrap0, lerr0, wrap5, lerr5;
`ifdef GRAYCOUNTER_12_LAP_EN
  logic       lap0, lap5;
`endif

  int checks = 0;
  int failures = 0;

  logic [3:0] gtab [12] = '{
    4'b0000, 4'b0001, 4'b0011, 4'b0010,
    4'b0110, 4'b0111, 4'b0101, 4'b0100,
    4'b1100, 4'b1101, 4'b1001, 4'b1000
  };

  int  m_cnt [2];
  bit  m_wrap [2];
  bit  m_lerr [2];
  bit  m_lap [2];
  int  m_rv [2] = '{0, 5};
  logic [3:0] prev_gray;

  always #5 clk = ~clk;

  graycounter_12 #(.RESET_VAL(4'd0)) u0 (
    .clk(clk), .reset(reset), .inc(inc), .clr(clr),
    .load(load), .load_bin(load_bin),
    .bin(bin0), .gray(gray0), .wrap(wrap0),
`ifdef GRAYCOUNTER_12_LAP_EN
    .lap(lap0),
`endif
    .load_err(lerr0)
  );

  graycounter_12 #(.RESET_VAL(4'd5)) u5 (
    .clk(clk), .reset(reset), .inc(inc), .clr(clr),
    .load(load), .load_bin(load_bin),
    .bin(bin5), .gray(gray5), .wrap(wrap5),
`ifdef GRAYCOUNTER_12_LAP_EN
    .lap(lap5),
`endif
    .load_err(lerr5)
  );

  task automatic chk(string tag, logic [3:0] obs,
                     logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic model_step(int i);
    if (reset) begin
      m_cnt[i] = m_rv[i];
      m_wrap[i] = 0; m_lerr[i] = 0; m_lap[i] = 0;
    end else begin
      m_wrap[i] = 0; m_lerr[i] = 0;
      if (clr) begin
        m_cnt[i] = 0; m_lap[i] = 0;
      end else if (load) begin
        if (int'(load_bin) >= 12) begin
          m_cnt[i] = 11; m_lerr[i] = 1;
        end else begin
          m_cnt[i] = int'(load_bin);
        end
      end else if (inc) begin
        if (m_cnt[i] == 11) begin
          m_wrap[i] = 1; m_lap[i] = !m_lap[i];
        end
        m_cnt[i] = (m_cnt[i] + 1) % 12;
      end
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".bin0"}, bin0, 4'(m_cnt[0]));
    chk({tag, ".gray0"}, gray0, gtab[m_cnt[0]]);
    chk({tag, ".wrap0"}, {3'b0, wrap0}, {3'b0, m_wrap[0]});
    chk({tag, ".lerr0"}, {3'b0, lerr0}, {3'b0, m_lerr[0]});
    chk({tag, ".bin5"}, bin5, 4'(m_cnt[1]));
    chk({tag, ".gray5"}, gray5, gtab[m_cnt[1]]);
    chk({tag, ".wrap5"}, {3'b0, wrap5}, {3'b0, m_wrap[1]});
    chk({tag, ".lerr5"}, {3'b0, lerr5}, {3'b0, m_lerr[1]});
`ifdef GRAYCOUNTER_12_LAP_EN
    chk({tag, ".lap0"}, {3'b0, lap0}, {3'b0, m_lap[0]});
    chk({tag, ".lap5"}, {3'b0, lap5}, {3'b0, m_lap[1]});
`endif
  endtask

  task automatic step(string tag, logic r, logic c, logic l,
                      logic [3:0] lb, logic n);
    reset = r; clr = c; load = l; load_bin = lb; inc = n;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check_all(tag);
  endtask

  initial begin
    reset = 1'b1; inc = 1'b0; clr = 1'b0;
    load = 1'b0; load_bin = 4'd0;

    step("rst1", 1, 0, 0, 4'd0, 0);
    step("rst2", 1, 0, 0, 4'd0, 0);
    chk("rst_gray5_lit", gray5, 4'b0111);

    prev_gray = gray0;
    for (int k = 0; k < 13; k++) begin
      step("cycle", 0, 0, 0, 4'd0, 1);
      chk("hamming", 4'($countones(gray0 ^ prev_gray)), 4'd1);
      prev_gray = gray0;
    end

    step("ld7", 0, 0, 1, 4'd7, 0);
    step("prio_clr", 0, 1, 1, 4'd3, 1);
    step("prio_ld", 0, 0, 1, 4'd3, 1);
    chk("prio_ld_lit", gray0, 4'b0010);
    step("hold", 0, 0, 0, 4'd9, 0);

    step("ld14", 0, 0, 1, 4'd14, 0);
    step("ld14_inc", 0, 0, 0, 4'd0, 1);
    step("ld0", 0, 0, 1, 4'd0, 0);
    step("ld15", 0, 0, 1, 4'd15, 1);
    step("clr11", 0, 1, 0, 4'd0, 0);

    step("ld10", 0, 0, 1, 4'd10, 0);
    step("inc10", 0, 0, 0, 4'd0, 1);
    step("midrst", 1, 0, 0, 4'd0, 1);
    for (int k = 0; k < 4; k++)
      step("resume", 0, 0, 0, 4'd0, 1);

    step("laprst", 1, 0, 0, 4'd0, 0);
    for (int k = 0; k < 24; k++)
      step("lap24", 0, 0, 0, 4'd0, 1);
    for (int k = 0; k < 14; k++)
      step("lap_more", 0, 0, 0, 4'd0, 1);
    step("ld_keep", 0, 0, 1, 4'd4, 0);
    step("lap_clr", 0, 1, 0, 4'd0, 1);

    for (int k = 0; k < 400; k++) begin
      logic r, c, l, n;
      logic [3:0] lb;
      r  = ($urandom_range(0, 39) == 0);
      c  = ($urandom_range(0, 19) == 0);
      l  = ($urandom_range(0, 7) == 0);
      n  = ($urandom_range(0, 3) != 0);
      lb = 4'($urandom_range(0, 15));
      step("rand", r, c, l, lb, n);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/graycounter_12.md
Name: graycounter_12

Overview:
- Mod-12 Gray-code pointer generator. It is the encoding end of the 12-state Gray sequence that graydecoder_12 consumes.
- Holds a binary count 0..11 and emits the registered 4-bit Gray code, so a pointer can cross into another clock domain glitch-free.
- Sits on the write side of the 12-entry PCS25G gearbox FIFO; the read side decodes the synchronised code.

Parameters:
- RESET_VAL, 0, binary count loaded at reset; legal 0..11.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous reset, active-high.
- inc  input  1  advance pointer by one this cycle.
- clr  input  1  synchronous clear to count 0 (no wrap pulse).
- load  input  1  load load_bin into the pointer.
- load_bin  input  4  binary load value.
- bin  output  4  registered binary count, 0..11.
- gray  output  4  registered Gray code of bin.
- wrap  output  1  one-cycle pulse: the count just went 11->0 by increment.
- load_err  output  1  one-cycle pulse: load_bin was out of range (12..15).

Behaviour:
- Reset (clk edge with reset=1): bin=RESET_VAL, gray=code(RESET_VAL), wrap=0, load_err=0; reset overrides every other input.
- Gray table, count 0..11: 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1001, 1000.
- Codes 1010, 1011, 1110, 1111 are never driven.
- Priority per edge: reset > clr > load > inc.
- Increment:
  - bin_next = (bin==11) ? 0 : bin+1.
  - Only one gray bit changes per increment, including 1000->0000.
- Load:
  - load_bin 0..11 is taken as is.
  - load_bin 12..15 clamps to 11 and pulses load_err for one cycle.
- clr: bin=0, gray=0000, wrap=0.
- Latency: inputs are sampled on the edge; bin and gray are valid the following cycle. gray is always a flop output, never combinational from bin.
- wrap: registered, asserted for exactly the cycle in which bin shows 0 after an 11->0 increment. Not asserted on clr, load-to-0 or reset.
- inc held high continuously: counter cycles every clock, and wrap pulses once per 12 cycles.
- inc=0 with no clr/load: all state holds, pulses drop to 0.
- clr/load concurrent with inc: inc is ignored that cycle.
- Reset mid-sequence: next cycle shows RESET_VAL with all pulses low.
- Internal state machine: the 12-state count only. No illegal states are reachable; a defensive default decodes any corrupt bin to 0 on the next increment.

Optional Feature:
- Macro: GRAYCOUNTER_12_LAP_EN.
- With it defined:
  - Extra output port lap (1 bit). Reset 0; toggles on every 11->0 increment; cleared by clr.
  - On load, lap is unchanged.
  - {lap, gray} forms a 24-state pointer for FIFO full/empty compare.
- Without it: no lap port and no lap flop.

Decomposition:
- Package gray12_pkg:
  - localparam MOD12=12, MAXCNT=4'd11.
  - Constants G0..G11 holding the table codes.
  - Function bin2gray12 (4-bit bin -> 4-bit gray; out-of-range input returns G11).
  - This package is shared with graydecoder_12 users.
- One natural sub-module: gray12_enc, a purely combinational bin->gray lookup feeding the gray register.
- Next-state/priority logic and the pulse flops stay in the top module.

Test Plan:
- Reset check: reset=1 for 2 cycles with RESET_VAL=0 -> bin=0, gray=0000, wrap=0, load_err=0. Repeat with RESET_VAL=5 -> gray=0111.
- Full cycle: reset then inc=1 for 13 cycles -> gray steps 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1001,1000,0000. wrap=1 only on the 12th post-reset cycle (bin=0). Every step has Hamming distance 1.
- Priority: bin=7, then one cycle with clr=1, load=1, load_bin=3, inc=1 -> bin=0, gray=0000, wrap=0. Next cycle load=1, load_bin=3, inc=1 -> bin=3, gray=0010.
- Out-of-range load: load_bin=14, load=1 -> bin=11, gray=1000, load_err high one cycle. Then inc -> bin=0, wrap=1.
- Reset mid-operation: reset asserted at bin=10 with inc held high -> next cycle bin=RESET_VAL, wrap=0. Counting resumes after reset drops.
- With GRAYCOUNTER_12_LAP_EN: 24 increments from reset -> lap toggles 0->1 at the first wrap and 1->0 at the second. clr at lap=1 -> lap=0.
